// File: rtl/wfg_drive_spi_arb_pkg.sv
// Shared types and the rotating-priority pick helper for the wfg_drive_spi stream arbiter.
package wfg_drive_spi_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_e;

   localparam int unsigned RR_MAX_SRC = 8;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_pick_t;

   // First set request at or after ptr, wrapping modulo num_src.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX_SRC-1:0] req,
                                        input logic [2:0]            ptr,
                                        input int unsigned           num_src);
      rr_pick_t    res;
      int unsigned pos;
      res = '0;
      for (int unsigned k = 0; k < RR_MAX_SRC; k++) begin
         pos = (32'(ptr) + k) % num_src;
         if ((k < num_src) && !res.found && req[pos[2:0]]) begin
            res.found = 1'b1;
            res.idx   = pos[2:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/wfg_drive_spi_arb_rr.sv
// Combinational round-robin picker: lowest-distance requester starting from ptr_i.
module wfg_drive_spi_arb_rr
   import wfg_drive_spi_arb_pkg::*;
#(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               found_o,
   output logic [IDX_W-1:0]   idx_o
);

   rr_pick_t pick;

   always_comb begin
      pick    = rr_pick(RR_MAX_SRC'(req_i), 3'(ptr_i), NUM_SRC);
      found_o = pick.found;
      idx_o   = IDX_W'(pick.idx);
   end

endmodule

// File: rtl/wfg_drive_spi_arb.sv
// Per-frame round-robin arbiter sharing one wfg_drive_spi AXI-Stream input among NUM_SRC sources.
module wfg_drive_spi_arb
   import wfg_drive_spi_arb_pkg::*;
#(
   parameter int unsigned NUM_SRC         = 4,
   parameter int unsigned AXIS_DATA_WIDTH = 32,
   parameter int unsigned BEAT_CNT_W      = 8,
   localparam int unsigned IDX_W          = $clog2(NUM_SRC)
) (
   input  logic                               wb_clk_i,
   input  logic                               wb_rst_i,
   input  logic                               ctrl_en_i,
   input  logic [NUM_SRC-1:0]                 cfg_mask_i,
   input  logic                               cfg_sync_i,
   input  logic [BEAT_CNT_W-1:0]              cfg_max_beats_i,
   input  logic                               wfg_pat_sync_i,
   input  logic [NUM_SRC-1:0]                 s_axis_tvalid_i,
   input  logic [NUM_SRC*AXIS_DATA_WIDTH-1:0] s_axis_tdata_i,
   input  logic [NUM_SRC-1:0]                 s_axis_tlast_i,
   output logic [NUM_SRC-1:0]                 s_axis_tready_o,
   output logic                               m_axis_tvalid_o,
   output logic [AXIS_DATA_WIDTH-1:0]         m_axis_tdata_o,
   output logic                               m_axis_tlast_o,
   input  logic                               m_axis_tready_i,
   output logic [IDX_W-1:0]                   grant_id_o,
   output logic                               busy_o,
   output logic                               trunc_o
);

   arb_state_e            state_q, state_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]      grant_q, grant_d;
   logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

   logic [NUM_SRC-1:0]    req;
   logic                  pick_found;
   logic [IDX_W-1:0]      pick_idx;
   logic                  locked, launch, hs, limit_hit, src_last;

   assign req    = s_axis_tvalid_i & cfg_mask_i;
   assign locked = (state_q == ARB_LOCK);

   wfg_drive_spi_arb_rr #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req_i   (req),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   always_comb begin
      s_axis_tready_o = '0;
      m_axis_tvalid_o = 1'b0;
      m_axis_tdata_o  = '0;
      src_last        = 1'b0;
      if (locked) begin
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_q == IDX_W'(i)) begin
               m_axis_tvalid_o    = s_axis_tvalid_i[i];
               m_axis_tdata_o     = s_axis_tdata_i[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
               src_last           = s_axis_tlast_i[i];
               s_axis_tready_o[i] = m_axis_tready_i;
            end
         end
      end
   end

   // Limit fires on the beat that brings the count up to cfg_max_beats_i.
   assign limit_hit      = locked && (cfg_max_beats_i != '0) &&
                           (beat_cnt_q == cfg_max_beats_i - BEAT_CNT_W'(1));
   assign m_axis_tlast_o = src_last | limit_hit;
   assign hs             = m_axis_tvalid_o & m_axis_tready_i;
   assign trunc_o        = hs & limit_hit & ~src_last;
   assign launch         = !locked && ctrl_en_i && pick_found && (!cfg_sync_i || wfg_pat_sync_i);
   assign busy_o         = locked;
   assign grant_id_o     = grant_q;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         ARB_IDLE: begin
            if (launch) begin
               grant_d    = pick_idx;
               beat_cnt_d = '0;
               state_d    = ARB_LOCK;
            end
         end
         ARB_LOCK: begin
            if (hs) begin
               beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
            end
            if (hs && m_axis_tlast_o) begin
               state_d  = ARB_IDLE;
               rr_ptr_d = (grant_q == IDX_W'(NUM_SRC-1)) ? '0 : grant_q + IDX_W'(1);
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= ARB_IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_wfg_drive_spi_arb.sv
// Directed bench for wfg_drive_spi_arb: queue-based sources, a frame-level arbiter model, and literal frame checks.
module tb_wfg_drive_spi_arb;

   localparam int unsigned NS = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             sync = 1'b0;
   logic             pat = 1'b0;
   logic             m_tready = 1'b0;
   logic [NS-1:0]    mask = '1;
   logic [BW-1:0]    max_beats = '0;
   logic [NS-1:0]    s_tvalid = '0;
   logic [NS-1:0]    s_tlast = '0;
   logic [NS*DW-1:0] s_tdata = '0;
   logic [NS-1:0]    s_tready;
   logic             m_tvalid, m_tlast, busy, trunc;
   logic [DW-1:0]    m_tdata;
   logic [1:0]       gid;

   always #5 clk = ~clk;

   wfg_drive_spi_arb #(
      .NUM_SRC         (NS),
      .AXIS_DATA_WIDTH (DW),
      .BEAT_CNT_W      (BW)
   ) dut (
      .wb_clk_i        (clk),
      .wb_rst_i        (rst),
      .ctrl_en_i       (en),
      .cfg_mask_i      (mask),
      .cfg_sync_i      (sync),
      .cfg_max_beats_i (max_beats),
      .wfg_pat_sync_i  (pat),
      .s_axis_tvalid_i (s_tvalid),
      .s_axis_tdata_i  (s_tdata),
      .s_axis_tlast_i  (s_tlast),
      .s_axis_tready_o (s_tready),
      .m_axis_tvalid_o (m_tvalid),
      .m_axis_tdata_o  (m_tdata),
      .m_axis_tlast_o  (m_tlast),
      .m_axis_tready_i (m_tready),
      .grant_id_o      (gid),
      .busy_o          (busy),
      .trunc_o         (trunc)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic          trunc;
      logic [1:0]    gid;
      int            cyc;
   } beat_t;

   logic [DW:0]   srcq [NS][$];
   logic [NS-1:0] hold = '0;
   logic [NS-1:0] hs_src = '0;
   beat_t         blog [$];
   int            cyc = 0;
   int            n_chk = 0;
   int            n_fail = 0;
   bit            chk_en = 1'b0;

   // Frame-level model: locked flag, granted source, rotating pointer, beats taken in this grant.
   bit            m_lock = 1'b0;
   logic [1:0]    m_g = '0;
   logic [1:0]    m_ptr = '0;
   int            m_beats = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic drive_srcs();
      for (int i = 0; i < NS; i++) begin
         if (srcq[i].size() != 0 && !hold[i]) begin
            s_tvalid[i]          = 1'b1;
            s_tdata[i*DW +: DW]  = srcq[i][0][DW-1:0];
            s_tlast[i]           = srcq[i][0][DW];
         end else begin
            s_tvalid[i]          = 1'b0;
            s_tdata[i*DW +: DW]  = '0;
            s_tlast[i]           = 1'b0;
         end
      end
   endtask

   task automatic push(input int src, input logic [DW-1:0] d, input logic l);
      srcq[src].push_back({l, d});
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic bit all_empty();
      bit e;
      e = 1'b1;
      for (int i = 0; i < NS; i++) if (srcq[i].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic wait_drained(input string nm, input int budget);
      int c;
      c = 0;
      while (!all_empty() && c < budget) begin
         step(1);
         c++;
      end
      check({nm, "_drain"}, 32'(all_empty()), 1);
      step(2);
   endtask

   task automatic wait_log(input string nm, input int n, input int budget);
      int c;
      c = 0;
      while (blog.size() < n && c < budget) begin
         step(1);
         c++;
      end
      check({nm, "_logwait"}, 32'(blog.size() >= n), 1);
   endtask

   task automatic chk_beat(input string nm, input int idx, input logic [DW-1:0] d,
                           input logic l, input logic t, input logic [1:0] g);
      if (idx >= blog.size()) begin
         check({nm, "_logsize"}, 32'(blog.size()), 32'(idx + 1));
      end else begin
         check({nm, "_data"}, blog[idx].data, d);
         check({nm, "_last"}, 32'(blog[idx].last), 32'(l));
         check({nm, "_trunc"}, 32'(blog[idx].trunc), 32'(t));
         check({nm, "_gid"}, 32'(blog[idx].gid), 32'(g));
      end
   endtask

   // Sources advance on the handshake seen just before the edge.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NS; i++) if (hs_src[i] === 1'b1) void'(srcq[i].pop_front());
      drive_srcs();
   end

   always @(negedge clk) begin : mdl
      logic [NS-1:0] e_tready, rq;
      logic          e_tvalid, e_last, e_trunc, lim, hsx;
      logic [DW-1:0] e_data;
      logic [1:0]    ix;
      int            pick;
      e_tready = '0;
      e_tvalid = 1'b0;
      e_last   = 1'b0;
      e_data   = '0;
      lim      = 1'b0;
      if (m_lock) begin
         e_tvalid      = s_tvalid[m_g];
         e_data        = s_tdata[m_g*DW +: DW];
         lim           = (max_beats != 0) && (m_beats + 1 == int'(max_beats));
         e_last        = s_tlast[m_g] || lim;
         e_tready[m_g] = m_tready;
      end
      hsx     = e_tvalid && m_tready;
      e_trunc = hsx && lim && !s_tlast[m_g];
      if (chk_en) begin
         check("tvalid", 32'(m_tvalid), 32'(e_tvalid));
         check("tdata", m_tdata, e_data);
         check("tlast", 32'(m_tlast), 32'(e_last));
         check("tready", 32'(s_tready), 32'(e_tready));
         check("busy", 32'(busy), 32'(m_lock));
         check("grant_id", 32'(gid), 32'(m_g));
         check("trunc", 32'(trunc), 32'(e_trunc));
         if (m_tvalid === 1'b1 && m_tready)
            blog.push_back('{data: m_tdata, last: m_tlast, trunc: trunc, gid: gid, cyc: cyc});
      end
      hs_src = s_tvalid & s_tready;
      if (rst) begin
         m_lock  = 1'b0;
         m_g     = '0;
         m_ptr   = '0;
         m_beats = 0;
         chk_en  = 1'b1;
      end else if (m_lock) begin
         if (hsx) begin
            m_beats++;
            if (e_last) begin
               m_lock = 1'b0;
               m_ptr  = 2'((int'(m_g) + 1) % NS);
            end
         end
      end else begin
         rq   = s_tvalid & mask;
         pick = -1;
         if (en && rq != 0 && (!sync || pat)) begin
            for (int k = 0; k < NS; k++) begin
               ix = 2'((int'(m_ptr) + k) % NS);
               if (pick < 0 && rq[ix]) pick = int'(ix);
            end
            m_g     = 2'(pick);
            m_lock  = 1'b1;
            m_beats = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int base, lcyc, rbase;
      step(3);
      check("rst_busy", 32'(busy), 0);
      check("rst_tvalid", 32'(m_tvalid), 0);
      check("rst_gid", 32'(gid), 0);
      check("rst_tready", 32'(s_tready), 0);
      rst = 1'b0;
      en = 1'b1;
      m_tready = 1'b1;

      // Two 3-beat frames, then pointer at 3 decides between sources 1 and 3.
      base = blog.size();
      push(0, 32'hA0, 0); push(0, 32'hA1, 0); push(0, 32'hA2, 1);
      push(2, 32'hC0, 0); push(2, 32'hC1, 0); push(2, 32'hC2, 1);
      drive_srcs();
      wait_drained("t1", 40);
      chk_beat("t1_a0", base + 0, 32'hA0, 0, 0, 0);
      chk_beat("t1_a1", base + 1, 32'hA1, 0, 0, 0);
      chk_beat("t1_a2", base + 2, 32'hA2, 1, 0, 0);
      chk_beat("t1_c0", base + 3, 32'hC0, 0, 0, 2);
      chk_beat("t1_c2", base + 5, 32'hC2, 1, 0, 2);
      check("t1_gap", 32'(blog[base+3].cyc - blog[base+2].cyc), 2);
      base = blog.size();
      push(1, 32'hB0, 1); push(3, 32'hD0, 1);
      drive_srcs();
      wait_drained("t1p", 20);
      chk_beat("t1_d0", base + 0, 32'hD0, 1, 0, 3);
      chk_beat("t1_b0", base + 1, 32'hB0, 1, 0, 1);

      // Sync-aligned launch.
      sync = 1'b1;
      pat = 1'b1; step(1); pat = 1'b0;
      check("t2_nolaunch", 32'(busy), 0);
      base = blog.size();
      push(1, 32'h10, 0); push(1, 32'h11, 1);
      drive_srcs();
      step(7);
      check("t2_wait", 32'(blog.size()), 32'(base));
      check("t2_tready", 32'(s_tready), 0);
      pat = 1'b1; lcyc = cyc; step(1); pat = 1'b0;
      check("t2_busy", 32'(busy), 1);
      wait_drained("t2", 20);
      chk_beat("t2_b0", base + 0, 32'h10, 0, 0, 1);
      chk_beat("t2_b1", base + 1, 32'h11, 1, 0, 1);
      check("t2_latency", 32'(blog[base].cyc), 32'(lcyc + 1));
      sync = 1'b0;

      // Beat limit of 2 splits source 3's frame around source 0.
      max_beats = 8'd2;
      base = blog.size();
      push(3, 32'h30, 0); push(3, 32'h31, 0); push(3, 32'h32, 0); push(3, 32'h33, 0); push(3, 32'h34, 1);
      push(0, 32'h50, 0); push(0, 32'h51, 1);
      drive_srcs();
      wait_drained("t3", 60);
      chk_beat("t3_30", base + 0, 32'h30, 0, 0, 3);
      chk_beat("t3_31", base + 1, 32'h31, 1, 1, 3);
      chk_beat("t3_50", base + 2, 32'h50, 0, 0, 0);
      chk_beat("t3_51", base + 3, 32'h51, 1, 0, 0);
      chk_beat("t3_32", base + 4, 32'h32, 0, 0, 3);
      chk_beat("t3_33", base + 5, 32'h33, 1, 1, 3);
      chk_beat("t3_34", base + 6, 32'h34, 1, 0, 3);
      max_beats = '0;

      // Backpressure and valid drop mid-frame while another source waits.
      base = blog.size();
      push(2, 32'h60, 0); push(2, 32'h61, 0); push(2, 32'h62, 0); push(2, 32'h63, 1);
      drive_srcs();
      step(1);
      push(1, 32'h70, 1);
      drive_srcs();
      for (int k = 0; k < 10; k++) begin
         m_tready = (k == 1 || k == 2 || k == 5) ? 1'b0 : 1'b1;
         hold[2]  = (k == 3 || k == 4);
         drive_srcs();
         step(1);
      end
      m_tready = 1'b1; hold = '0; drive_srcs();
      wait_drained("t4", 40);
      check("t4_count", 32'(blog.size()), 32'(base + 5));
      chk_beat("t4_60", base + 0, 32'h60, 0, 0, 2);
      chk_beat("t4_61", base + 1, 32'h61, 0, 0, 2);
      chk_beat("t4_62", base + 2, 32'h62, 0, 0, 2);
      chk_beat("t4_63", base + 3, 32'h63, 1, 0, 2);
      chk_beat("t4_70", base + 4, 32'h70, 1, 0, 1);

      // Enable dropped mid-frame: frame completes, no new launch until re-enabled.
      base = blog.size();
      push(0, 32'h80, 0); push(0, 32'h81, 0); push(0, 32'h82, 0); push(0, 32'h83, 1);
      drive_srcs();
      wait_log("t5", base + 2, 20);
      en = 1'b0;
      push(1, 32'h90, 1);
      drive_srcs();
      step(10);
      check("t5_count", 32'(blog.size()), 32'(base + 4));
      check("t5_busy", 32'(busy), 0);
      chk_beat("t5_82", base + 2, 32'h82, 0, 0, 0);
      chk_beat("t5_83", base + 3, 32'h83, 1, 0, 0);
      en = 1'b1;
      wait_drained("t5", 20);
      chk_beat("t5_90", base + 4, 32'h90, 1, 0, 1);

      // Reset mid-frame abandons the grant; arbitration restarts at source 0.
      base = blog.size();
      push(2, 32'hE0, 0); push(2, 32'hE1, 0); push(2, 32'hE2, 0); push(2, 32'hE3, 0); push(2, 32'hE4, 1);
      drive_srcs();
      wait_log("t6", base + 2, 20);
      rst = 1'b1; step(1); rst = 1'b0;
      check("t6_tready", 32'(s_tready), 0);
      check("t6_tvalid", 32'(m_tvalid), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_gid", 32'(gid), 0);
      check("t6_trunc", 32'(trunc), 0);
      rbase = blog.size();
      push(0, 32'hF0, 1);
      drive_srcs();
      wait_drained("t6", 40);
      chk_beat("t6_f0", rbase, 32'hF0, 1, 0, 0);
      check("t6_next_gid", 32'(blog[rbase+1].gid), 2);

      step(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wfg_drive_spi_arb.md
Name: wfg_drive_spi_arb

Overview:
- Round-robin frame arbiter that shares one wfg_drive_spi AXI-Stream input between NUM_SRC upstream streams.
- Grants are per frame. A frame ends on tlast, or is cut off at a beat limit.
- New grants can optionally be aligned to the core pattern-sync pulse, so frames from different sources start on pattern boundaries.
- Sits between the waveform sources and wfg_drive_spi_top. Configuration comes from the subsystem register block.

Parameters:
- NUM_SRC, 4, number of upstream stream sources (2..8).
- AXIS_DATA_WIDTH, 32, stream data width.
- BEAT_CNT_W, 8, width of the beat limit and beat counter.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- ctrl_en_i  in  1  arbiter enable
- cfg_mask_i  in  NUM_SRC  per-source enable; 1 = source may be granted
- cfg_sync_i  in  1  1 = launch grants only on wfg_pat_sync_i
- cfg_max_beats_i  in  BEAT_CNT_W  beat limit per grant; 0 = unlimited
- wfg_pat_sync_i  in  1  pattern sync pulse
- s_axis_tvalid_i  in  NUM_SRC  source valid
- s_axis_tdata_i  in  NUM_SRC*AXIS_DATA_WIDTH  source data; source i at [i*W +: W]
- s_axis_tlast_i  in  NUM_SRC  source last
- s_axis_tready_o  out  NUM_SRC  source ready
- m_axis_tvalid_o  out  1  to wfg_drive_spi valid
- m_axis_tdata_o  out  AXIS_DATA_WIDTH  to wfg_drive_spi data
- m_axis_tlast_o  out  1  to wfg_drive_spi last
- m_axis_tready_i  in  1  from wfg_drive_spi ready
- grant_id_o  out  $clog2(NUM_SRC)  index of the current or last granted source
- busy_o  out  1  a grant is held
- trunc_o  out  1  one-cycle pulse when a frame is cut off at the beat limit

Behaviour:
- Reset (synchronous on wb_rst_i):
  - state=IDLE, rr_ptr=0, grant_id_o=0, beat_cnt=0.
  - All tready_o=0, m_axis_tvalid_o=0, m_axis_tlast_o=0, m_axis_tdata_o=0, busy_o=0, trunc_o=0.
  - A reset during a frame abandons the frame; no further beats are forwarded.
- Request vector: req = s_axis_tvalid_i & cfg_mask_i.
- States:
  - IDLE:
    - Launch condition: ctrl_en_i=1, |req=1, and (cfg_sync_i=0 or wfg_pat_sync_i=1).
    - On launch, pick the first set req bit searching rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
    - Register the pick into grant_id_o, clear beat_cnt, go to LOCK.
    - All tready_o stay 0 in IDLE.
    - Arbitration latency is 1 cycle: the first beat can transfer in the cycle after launch.
    - Sync pulses while |req=0 are ignored; they are not remembered.
  - LOCK (combinational pass-through, zero added latency):
    - m_axis_tvalid_o = s_axis_tvalid_i[g]; m_axis_tdata_o = slice g of s_axis_tdata_i.
    - s_axis_tready_o[g] = m_axis_tready_i; all other tready_o = 0.
    - busy_o=1.
    - A handshake is m_axis_tvalid_o & m_axis_tready_i; each handshake increments beat_cnt.
    - limit_hit = (cfg_max_beats_i != 0) and (beat_cnt == cfg_max_beats_i - 1).
    - m_axis_tlast_o = s_axis_tlast_i[g] | limit_hit.
    - Frame end: a handshake with m_axis_tlast_o=1. Next state IDLE, rr_ptr = (g+1) mod NUM_SRC.
    - On a limit-forced end where the source's own tlast was 0, pulse trunc_o for one cycle. The source continues its frame at its next grant.
- Masking and enable changes while in LOCK:
  - cfg_mask_i changes, or deasserting the mask bit of the granted source, do not revoke the grant. The frame completes.
  - ctrl_en_i=0 during LOCK also lets the frame complete. The block then stays in IDLE until re-enabled.
- cfg_max_beats_i is sampled on every cycle; software changes it only while busy_o=0.
- In IDLE, m_axis_tdata_o holds 0 and tlast 0. m_axis_tvalid_o is never asserted outside LOCK.
- When a source's tvalid drops mid-frame, the arbiter holds the grant; there is no timeout.
- An idle-cycle pat_sync in the same cycle as the first req still launches, because the launch condition is evaluated combinationally.

Decomposition:
- Package wfg_drive_spi_arb_pkg:
  - state enum arb_state_e {ARB_IDLE, ARB_LOCK}.
  - Function rr_pick(req, ptr) returning the index and a found flag.
- Sub-module wfg_drive_spi_arb_rr holds the rotating-priority pick logic: combinational, parameterised by NUM_SRC.
- The top contains the FSM, beat counter and the AXI-Stream mux.

Test Plan:
- NUM_SRC=4, mask=4'hF, cfg_sync=0; sources 0 and 2 each hold a 3-beat frame (0xA0..A2, 0xC0..C2); m_tready=1 → output A0,A1,A2(tlast), one idle cycle, then C0,C1,C2(tlast); grant_id 0 then 2; rr_ptr ends at 3.
- cfg_sync=1; source 1 valid from cycle 5; pat_sync pulses at cycle 12 → no tready before cycle 13; first beat transfers in cycle 13; busy_o rises at 13.
- cfg_max_beats=2; source 3 sends a 5-beat frame → beats 0,1 forwarded with tlast forced on beat 1 and trunc_o pulsing; with source 0 also requesting, source 0 is granted next, then source 3 resumes with beat 2.
- m_tready toggles 1,0,0,1 and the source drops tvalid for 2 cycles mid-frame → no beat is lost or duplicated; no other source's tready rises while locked.
- ctrl_en deasserted after beat 1 of a 4-beat frame → beats 2,3 still delivered; afterwards no grant launches despite pending requests until ctrl_en=1.
- wb_rst_i asserted mid-frame for 1 cycle → next cycle all tready=0, m_tvalid=0, busy_o=0, grant_id_o=0; after release, arbitration restarts from source 0.
